// File: rtl/flash_cmd_pkg.sv
// Shared constants for the flash command core: unlock keys and addresses,
// opcodes, command FSM state encoding and status byte bit positions.
package flash_cmd_pkg;

    localparam logic [15:0] UNLOCK_A1  = 16'h5555;
    localparam logic [15:0] UNLOCK_A2  = 16'hAAAA;
    localparam logic [7:0]  KEY1       = 8'hAA;
    localparam logic [7:0]  KEY2       = 8'h55;

    localparam logic [7:0]  OP_PROG    = 8'h20;
    localparam logic [7:0]  OP_READ    = 8'h10;
    localparam logic [7:0]  OP_ERASE   = 8'h30;
    localparam logic [7:0]  OP_CONFIRM = 8'hD0;

    localparam int unsigned STAT_BUSY  = 7;
    localparam int unsigned STAT_ERR   = 6;
    localparam int unsigned STAT_WP    = 5;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_U1         = 3'd1,
        ST_U2         = 3'd2,
        ST_PROG_ARG   = 3'd3,
        ST_READ_ARG   = 3'd4,
        ST_ERASE_ARG  = 3'd5,
        ST_BUSY_PROG  = 3'd6,
        ST_BUSY_ERASE = 3'd7
    } cmdState_t;

endpackage

// File: rtl/flash_bus_sync.sv
// Bus front end: samples the strobes, captures Addr/IO during a write strobe
// and turns the strobe edges into single-clock event pulses.
// Ports:
//   clk, nReset              clock, async active-low reset
//   nEN, nWE, nRE            bus strobes (active low)
//   addr, ioIn               bus address and incoming IO data
//   wrEvt, wrAddr, wrData    write event pulse with last captured address/data
//   rdStart, rdAddr, rdEnd   read window start pulse (+ address), end pulse
module flash_bus_sync
    import flash_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              nEN,
    input  logic              nWE,
    input  logic              nRE,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] ioIn,
    output logic              wrEvt,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [DATA_W-1:0] wrData,
    output logic              rdStart,
    output logic [ADDR_W-1:0] rdAddr,
    output logic              rdEnd
);

    logic wrSeen;
    logic rdActive;
    logic readCond;

    // A cycle with nWE and nRE both low counts as a write, never a read.
    assign readCond = !nEN && !nRE && nWE;

    // Write capture / event generation and read window tracking.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wrSeen   <= 1'b0;
            wrEvt    <= 1'b0;
            wrAddr   <= '0;
            wrData   <= '0;
            rdActive <= 1'b0;
            rdStart  <= 1'b0;
            rdEnd    <= 1'b0;
            rdAddr   <= '0;
        end else begin
            wrEvt   <= 1'b0;
            rdStart <= 1'b0;
            rdEnd   <= 1'b0;
            if (!nEN && !nWE) begin
                wrAddr <= addr;
                wrData <= ioIn;
                wrSeen <= 1'b1;
            end else if (nWE && wrSeen) begin
                wrEvt  <= 1'b1;
                wrSeen <= 1'b0;
            end
            if (readCond && !rdActive) begin
                rdActive <= 1'b1;
                rdStart  <= 1'b1;
                rdAddr   <= addr;
            end else if (!readCond && rdActive) begin
                rdActive <= 1'b0;
                rdEnd    <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/flash_cmd_core.sv
// Flash array with a JEDEC-style unlock/command decoder: program (AND
// semantics), sequential sector erase, unlocked array read, status polling.
// Optional write protect via macro FLASH_CMD_WP_EN (adds nWP port).
// Ports:
//   Clk, nReset       clock, async active-low reset
//   nEN, nWE, nRE     bus strobes (active low)
//   Addr, IO          word address, bidirectional data bus
//   nWP               write protect, active low (FLASH_CMD_WP_EN only)
//   Busy              program/erase in progress
module flash_cmd_core
    import flash_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SECTOR_W    = 8,
    parameter int unsigned PROG_CYCLES = 4
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              nEN,
    input  logic              nWE,
    input  logic              nRE,
    input  logic [ADDR_W-1:0] Addr,
    inout  wire  [DATA_W-1:0] IO,
`ifdef FLASH_CMD_WP_EN
    input  logic              nWP,
`endif
    output logic              Busy
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned SECN_W = ADDR_W - SECTOR_W;
    localparam int unsigned CNT_W  = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  PROG_LAST = CNT_W'(PROG_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR1     = ADDR_W'(UNLOCK_A1);
    localparam logic [ADDR_W-1:0] ADDR2     = ADDR_W'(UNLOCK_A2);

    logic [DATA_W-1:0] mem [DEPTH];

    cmdState_t         state, stateNext;
    logic              wrEvt, rdStart, rdEnd;
    logic [ADDR_W-1:0] wrAddr, rdAddr;
    logic [DATA_W-1:0] wrData;
    logic [DATA_W-1:0] ioIn;

    logic              errQ;
    logic [ADDR_W-1:0] progAddrQ;
    logic [DATA_W-1:0] progDataQ;
    logic [SECN_W-1:0] sectorQ;
    logic [SECTOR_W-1:0] ptrQ;
    logic [CNT_W-1:0]  cntQ;
    logic              ioOe;
    logic [DATA_W-1:0] ioData;

    logic              wpLow;
    logic              isA1, isA2, isK1, isK2, isOpValid, isConfirm;
    logic [DATA_W-1:0] oldWord;
    logic              progConflict;
    logic [DATA_W-1:0] statusByte;

    logic              errSetC, errClrC, progLatchC, eraseLatchC, memWeC;
    logic [ADDR_W-1:0] memWAddrC;
    logic [DATA_W-1:0] memWDataC;

    assign ioIn = IO;
    assign IO   = ioOe ? ioData : {DATA_W{1'bz}};

    flash_bus_sync #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_sync (
        .clk    (Clk),
        .nReset (nReset),
        .nEN    (nEN),
        .nWE    (nWE),
        .nRE    (nRE),
        .addr   (Addr),
        .ioIn   (ioIn),
        .wrEvt  (wrEvt),
        .wrAddr (wrAddr),
        .wrData (wrData),
        .rdStart(rdStart),
        .rdAddr (rdAddr),
        .rdEnd  (rdEnd)
    );

`ifdef FLASH_CMD_WP_EN
    assign wpLow = ~nWP;
`else
    assign wpLow = 1'b0;
`endif

    // Write-event decode against unlock constants and opcodes.
    assign isA1      = (wrAddr == ADDR1);
    assign isA2      = (wrAddr == ADDR2);
    assign isK1      = (wrData[7:0] == KEY1);
    assign isK2      = (wrData[7:0] == KEY2);
    assign isOpValid = (wrData[7:0] == OP_PROG) || (wrData[7:0] == OP_READ) ||
                       (wrData[7:0] == OP_ERASE);
    assign isConfirm = (wrData[7:0] == OP_CONFIRM);

    // A program may only clear bits; any 1 over a stored 0 is an error.
    assign oldWord      = mem[progAddrQ];
    assign progConflict = |(progDataQ & ~oldWord);

    always_comb begin
        statusByte           = '0;
        statusByte[STAT_BUSY] = Busy;
        statusByte[STAT_ERR]  = errQ;
        statusByte[STAT_WP]   = wpLow;
    end

    // State register.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) state <= ST_IDLE;
        else         state <= stateNext;
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        unique case (state)
            ST_IDLE:
                if (wrEvt && isA1 && isK1) stateNext = ST_U1;
            ST_U1:
                if (wrEvt) stateNext = (isA2 && isK2) ? ST_U2 : ST_IDLE;
            ST_U2:
                if (wrEvt) begin
                    stateNext = ST_IDLE;
                    if (isA1 && wrData[7:0] == OP_PROG)  stateNext = ST_PROG_ARG;
                    if (isA1 && wrData[7:0] == OP_READ)  stateNext = ST_READ_ARG;
                    if (isA1 && wrData[7:0] == OP_ERASE) stateNext = ST_ERASE_ARG;
                end
            ST_PROG_ARG:
                if (wrEvt) stateNext = wpLow ? ST_IDLE : ST_BUSY_PROG;
            ST_ERASE_ARG:
                if (wrEvt) stateNext = (isConfirm && !wpLow) ? ST_BUSY_ERASE : ST_IDLE;
            ST_READ_ARG:
                if (wrEvt || rdEnd) stateNext = ST_IDLE;
            ST_BUSY_PROG:
                if (cntQ == PROG_LAST) stateNext = ST_IDLE;
            ST_BUSY_ERASE:
                if (&ptrQ) stateNext = ST_IDLE;
            default:
                stateNext = ST_IDLE;
        endcase
    end

    // Per-state control strobes.
    always_comb begin
        errSetC     = 1'b0;
        errClrC     = 1'b0;
        progLatchC  = 1'b0;
        eraseLatchC = 1'b0;
        memWeC      = 1'b0;
        memWAddrC   = progAddrQ;
        memWDataC   = oldWord & progDataQ;
        unique case (state)
            ST_IDLE:
                if (wrEvt && isA1 && isK1) errClrC = 1'b1;
            ST_U1:
                if (wrEvt && !(isA2 && isK2)) errSetC = 1'b1;
            ST_U2:
                if (wrEvt && !(isA1 && isOpValid)) errSetC = 1'b1;
            ST_PROG_ARG:
                if (wrEvt) begin
                    errSetC    = wpLow;
                    progLatchC = !wpLow;
                end
            ST_ERASE_ARG:
                if (wrEvt) begin
                    eraseLatchC = isConfirm && !wpLow;
                    errSetC     = !(isConfirm && !wpLow);
                end
            ST_READ_ARG:
                if (wrEvt) errSetC = 1'b1;
            ST_BUSY_PROG:
                if (cntQ == PROG_LAST) begin
                    memWeC  = 1'b1;
                    errSetC = progConflict;
                end
            ST_BUSY_ERASE: begin
                memWeC    = 1'b1;
                memWAddrC = {sectorQ, ptrQ};
                memWDataC = '1;
            end
            default: ;
        endcase
    end

    // Command datapath: error flag, latched arguments, busy counters.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            errQ      <= 1'b0;
            progAddrQ <= '0;
            progDataQ <= '0;
            sectorQ   <= '0;
            ptrQ      <= '0;
            cntQ      <= '0;
            Busy      <= 1'b0;
        end else begin
            if (errSetC)      errQ <= 1'b1;
            else if (errClrC) errQ <= 1'b0;
            if (progLatchC) begin
                progAddrQ <= wrAddr;
                progDataQ <= wrData;
            end
            if (eraseLatchC) sectorQ <= wrAddr[ADDR_W-1:SECTOR_W];
            if (state == ST_BUSY_PROG && cntQ != PROG_LAST) cntQ <= cntQ + CNT_W'(1);
            else                                            cntQ <= '0;
            // Wraps back to 0 on the last erased word.
            if (state == ST_BUSY_ERASE) ptrQ <= ptrQ + SECTOR_W'(1);
            Busy <= (stateNext == ST_BUSY_PROG) || (stateNext == ST_BUSY_ERASE);
        end
    end

    // Read window: drive one clock after the start pulse, release one after the end.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            ioOe   <= 1'b0;
            ioData <= '0;
        end else begin
            if (rdStart)    ioOe <= 1'b1;
            else if (rdEnd) ioOe <= 1'b0;
            ioData <= (state == ST_READ_ARG) ? mem[rdAddr] : statusByte;
        end
    end

    // Array write port; the array itself is never reset.
    always_ff @(posedge Clk) begin
        if (memWeC) mem[memWAddrC] <= memWDataC;
    end

endmodule

// File: doc/flash_cmd_core.md
Name: flash_cmd_core

Overview:
- Clocked, parametrised next-generation flash core with a JEDEC-style unlock/command decoder on the nEN/nWE/nRE/Addr/IO bus.
- Adds the following over the previous core:
  - generic address and data widths;
  - program with flash AND-semantics;
  - sequential sector erase;
  - a Busy/status byte for polling;
  - sequence-error reporting.
- Sits behind the host bus model in the system bench and is the target for the flash-controller work.

Parameters:
- ADDR_W, 16, address width; array depth = 2**ADDR_W words.
- DATA_W, 8, word and IO width; must be >= 8.
- SECTOR_W, 8, low address bits inside one sector; sector size = 2**SECTOR_W words.
- PROG_CYCLES, 4, Busy duration of a program operation in clocks; must be >= 1.

Ports:
- Clk  input  1  single clock; all bus inputs are sampled on its rising edge.
- nReset  input  1  asynchronous active-low reset.
- nEN  input  1  chip enable, active low.
- nWE  input  1  write strobe, active low.
- nRE  input  1  read strobe, active low.
- Addr  input  ADDR_W  word address.
- IO  inout  DATA_W  data bus; high-Z unless a read is being driven.
- Busy  output  1  high while a program or erase is in progress.

Behaviour:
- Reset: FSM goes to IDLE; Busy=0; Err=0; IO high-Z; the busy counter and erase pointer clear. The array is not reset.
- Write event:
  - While nEN=0 and nWE=0, Addr and IO are captured every clock.
  - The first clock that samples nWE=1 after a sampled nWE=0 is one write event, using the last captured values.
  - If nWE and nRE are low together, the cycle is a write and IO is not driven.
- Unlock constants: A1 = 16'h5555 and A2 = 16'hAAAA, each truncated or zero-extended to ADDR_W. K1 = 8'hAA and K2 = 8'h55 are compared on IO[7:0].
- FSM transitions on write events:
  - IDLE: (A1, K1) -> U1 and clears Err.
  - U1: (A2, K2) -> U2.
  - U2 at A1, opcode 8'h20 -> PROG_ARG.
  - U2 at A1, opcode 8'h10 -> READ_ARG.
  - U2 at A1, opcode 8'h30 -> ERASE_ARG.
  - Any other write in U1, U2 or ERASE_ARG -> IDLE and sets Err.
  - A write in IDLE that is not (A1, K1) is ignored.
  - PROG_ARG: any write latches (addr, data) -> BUSY_PROG with Busy=1 on the next clock.
  - ERASE_ARG: a write with data 8'hD0 latches the sector number Addr[ADDR_W-1:SECTOR_W] -> BUSY_ERASE.
  - READ_ARG: a write aborts to IDLE and sets Err.
- BUSY_PROG:
  - Busy stays high for exactly PROG_CYCLES clocks.
  - On the last clock, mem[addr] <= mem[addr] & data.
  - If the data had any 1 where the old word had 0, Err is set; the AND result is still written.
  - Then -> IDLE with Busy=0.
- BUSY_ERASE:
  - The pointer walks offsets 0 .. 2**SECTOR_W-1, writing all-ones one word per clock, so Busy lasts 2**SECTOR_W clocks.
  - The pointer wraps to 0 and the FSM returns to IDLE.
- During Busy, all write events are ignored and do not affect Err.
- Reads:
  - The first clock that samples nEN=0 and nRE=0 starts a read; IO is driven from the following clock and held until the clock after nEN or nRE is sampled high.
  - In READ_ARG the driven value is mem[Addr sampled at read start]; when the read ends the FSM -> IDLE.
  - In any other state the driven value is the status byte: bit7 = Busy, bit6 = Err, remaining bits 0.
- Reset mid-operation: the operation aborts. For program, the array is unchanged. For erase, words already erased stay erased.

Optional Feature:
- Macro FLASH_CMD_WP_EN.
- When defined:
  - Adds port nWP (input, 1 bit).
  - If nWP is sampled low at the PROG_ARG or ERASE_ARG latch event, the command is rejected: FSM -> IDLE, Err=1, no Busy, array unchanged.
  - Status bit5 reflects ~nWP.
- When undefined: there is no nWP port, status bit5 is 0, and nothing is ever protected.

Decomposition:
- Package flash_cmd_pkg holds:
  - the opcodes (OP_PROG 8'h20, OP_READ 8'h10, OP_ERASE 8'h30, OP_CONFIRM 8'hD0);
  - the unlock keys and addresses;
  - the FSM state encoding (IDLE, U1, U2, PROG_ARG, READ_ARG, ERASE_ARG, BUSY_PROG, BUSY_ERASE);
  - the status bit positions.
- One sub-module, flash_bus_sync: samples nEN/nWE/nRE, captures Addr/IO, and emits single-clock wr_evt, rd_start and rd_end pulses.

Test Plan:
- Reset, then the program sequence (5555/AA, AAAA/55, 5555/20, 1234/99) -> Busy high exactly 4 clocks; an unlocked read of 1234 then returns 8'h99.
- Program 1234/F0 over 8'h99 -> stored value 8'h90, status byte 8'h40 (Err set).
- Erase sequence (…5555/30, 1200/D0) -> Busy high 256 clocks; afterwards a read of 12FF returns 8'hFF and a read of 1300 is unchanged.
- Plain nRE cycle with no unlock during a program -> IO = 8'h80; after completion IO = 8'h00; IO is high-Z outside read windows.
- Bad key (5555/AA, AAAA/54) -> FSM returns to IDLE and status = 8'h40; the next 5555/AA clears Err.
- nReset pulsed low at clock 2 of a program -> Busy=0 immediately and the target word is unchanged. With FLASH_CMD_WP_EN and nWP=0, a program sequence leaves the array unchanged and status = 8'h60.
